// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: one shared valid/ready channel, NR_REQ requesters,
// grant locked from first beat until the last beat of a packet is accepted.
module rr_packet_arbiter #(
   parameter int NR_REQ     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = $clog2(NR_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NR_REQ-1:0]            req_valid,
   output logic [NR_REQ-1:0]            req_ready,
   input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NR_REQ-1:0]            req_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_last,
   output logic [NR_REQ-1:0]            grant,
   output logic [IDX_W-1:0]             grant_idx
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                 state_q;
   logic [NR_REQ-1:0]      grant_q;
   logic [IDX_W-1:0]       grant_idx_q;
   logic [IDX_W-1:0]       ptr_q;

   logic [NR_REQ-1:0]      grant_d;
   logic [IDX_W-1:0]       grant_idx_d;
   logic [IDX_W-1:0]       ptr_d;
   logic                   any_req;
   logic                   xfer;
   logic [DATA_WIDTH-1:0]  sel_data;

   // Scan from ptr upward with wrap; the lowest offset holding a valid wins.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NR_REQ-1:0] vld,
                                                input logic [IDX_W-1:0]  ptr);
      logic [IDX_W-1:0] sel;
      int               idx;
      sel = '0;
      for (int k = NR_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NR_REQ;
         if (vld[idx]) begin
            sel = IDX_W'(idx);
         end
      end
      return sel;
   endfunction

   assign any_req     = |req_valid;
   assign grant_idx_d = rr_pick(req_valid, ptr_q);
   assign grant_d     = NR_REQ'(1) << grant_idx_d;
   assign ptr_d       = (grant_idx_q == IDX_W'(NR_REQ - 1)) ? '0
                                                             : grant_idx_q + IDX_W'(1);

   // AND-OR select: a zero grant forces every output to zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         sel_data = sel_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
      end
   end

   assign out_data  = sel_data;
   assign out_valid = |(req_valid & grant_q);
   assign out_last  = |(req_last & grant_q);
   assign req_ready = grant_q & {NR_REQ{out_ready}};
   assign xfer      = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         ptr_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q     <= grant_d;
                  grant_idx_q <= grant_idx_d;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               // Only the accepted last beat releases the lock.
               if (xfer && out_last) begin
                  grant_q     <= '0;
                  grant_idx_q <= '0;
                  ptr_q       <= ptr_d;
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign grant_idx = grant_idx_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_idx_matches   : assert property (@(posedge clk) disable iff (rst)
                        (grant_q == '0) ? (grant_idx_q == '0) : grant_q[grant_idx_q]);
   a_state_matches : assert property (@(posedge clk) disable iff (rst)
                        (state_q == BUSY) == (grant_q != '0));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter with NR_REQ=4, DATA_WIDTH=8.
module tb_rr_packet_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [3:0]  grant;
   logic [1:0]  grant_idx;

   int checks   = 0;
   int failures = 0;

   rr_packet_arbiter #(.NR_REQ(4), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_last  (req_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_last  = '0;
      req_data  = 32'hDEAD_BEEF;
      out_ready = 1'b0;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'h44_33_22_11;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL reset_grant: got %b want 0000", grant);
      end
      checks++;
      if (grant_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_grant_idx: got %0d want 0", grant_idx);
      end
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_data !== 8'h00 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b ready=%b data=%h last=%b want 0/0000/00/0",
                  out_valid, req_ready, out_data, out_last);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_release_grant: got %b idx %0d want 0001 idx 0", grant, grant_idx);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0100;
      req_last  = 4'b0100;
      req_data  = 32'h77_A5_66_55;
      out_ready = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
         failures++;
         $display("FAIL single_grant: got %b idx %0d want 0100 idx 2", grant, grant_idx);
      end
      checks++;
      if (out_data !== 8'hA5 || out_valid !== 1'b1 || out_last !== 1'b1) begin
         failures++;
         $display("FAIL single_out: data=%h valid=%b last=%b want a5/1/1", out_data, out_valid, out_last);
      end
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      tick();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL single_release: got %b want 0000", grant);
      end
      // ptr should now be 3, so requester 3 wins over 0..2
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      tick();
      checks++;
      if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
         failures++;
         $display("FAIL single_ptr3: got %b idx %0d want 1000 idx 3", grant, grant_idx);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_seq [9];
      exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'h44_33_22_11;
      out_ready = 1'b1;
      for (int s = 0; s < 9; s++) begin
         tick();
         checks++;
         if (grant !== exp_seq[s]) begin
            failures++;
            $display("FAIL contention_step%0d: got %b want %b", s, grant, exp_seq[s]);
         end
      end
      checks++;
      if (out_data !== 8'h11) begin
         failures++;
         $display("FAIL contention_data: got %h want 11", out_data);
      end
   endtask

   task automatic test_packet_lock();
      logic [7:0] exp_d;
      do_reset();
      req_valid = 4'b0011;
      req_last  = 4'b0000;
      req_data  = 32'h00_00_EE_10;
      out_ready = 1'b1;
      tick();
      for (int b = 1; b <= 3; b++) begin
         exp_d = 8'h10 + 8'(b);
         req_data[7:0] = exp_d;
         req_last[0]   = (b == 3);
         #1;
         checks++;
         if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL lock_beat%0d: grant=%b ready=%b want 0001/0001", b, grant, req_ready);
         end
         checks++;
         if (out_data !== exp_d || out_last !== (b == 3)) begin
            failures++;
            $display("FAIL lock_data%0d: data=%h last=%b want %h/%b", b, out_data, out_last, exp_d, (b == 3));
         end
         tick();
      end
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL lock_bubble: got %b want 0000", grant);
      end
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      tick();
      checks++;
      if (grant !== 4'b0010 || out_data !== 8'hEE) begin
         failures++;
         $display("FAIL lock_next: grant=%b data=%h want 0010/ee", grant, out_data);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      req_data  = 32'h00_00_3C_00;
      out_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (grant !== 4'b0010 || out_valid !== 1'b1 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_stall%0d: grant=%b valid=%b ready=%b want 0010/1/0000",
                     c, grant, out_valid, req_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010 || out_data !== 8'h3C) begin
         failures++;
         $display("FAIL bp_ready: ready=%b data=%h want 0010/3c", req_ready, out_data);
      end
      tick();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL bp_release: got %b want 0000", grant);
      end
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      tick();
      checks++;
      if (grant !== 4'b0100) begin
         failures++;
         $display("FAIL bp_ptr: got %b want 0100", grant);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      out_ready = 1'b1;
      tick();
      tick();
      req_valid = 4'b0101;
      req_last  = 4'b0000;
      tick();
      checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
         failures++;
         $display("FAIL mid_setup: got %b idx %0d want 0100 idx 2", grant, grant_idx);
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0000 || grant_idx !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: grant=%b idx=%0d valid=%b want 0000/0/0", grant, grant_idx, out_valid);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (grant !== 4'b0001) begin
         failures++;
         $display("FAIL mid_rearb: got %b want 0001", grant);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_packet_lock();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
